// File: rtl/pkt_frame_pkg.sv
// Shared types and helpers for the per-channel packet framing monitor.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package pkt_frame_pkg;

    // Channel FSM encoding; these values are visible on the state output bus.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HEAD = 3'd1,
        ST_DATA = 3'd2,
        ST_TAIL = 3'd3,
        ST_ERR  = 3'd4
    } chan_state_e;

    // Beat classes decoded from valid/head/tail.
    typedef enum logic [2:0] {
        BEAT_NONE = 3'd0,
        BEAT_BODY = 3'd1,
        BEAT_H    = 3'd2,
        BEAT_T    = 3'd3,
        BEAT_HT   = 3'd4
    } beat_e;

    localparam int STATE_W = 3;

    // Width of a beat counter able to hold 0..max_len.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // head/tail are ignored without valid; head together with tail is its own class.
    function automatic beat_e classify(input logic v, input logic h, input logic t);
        beat_e b;
        if (!v)            b = BEAT_NONE;
        else if (h && t)   b = BEAT_HT;
        else if (h)        b = BEAT_H;
        else if (t)        b = BEAT_T;
        else               b = BEAT_BODY;
        return b;
    endfunction

endpackage

// File: rtl/pkt_chan_fsm.sv
// Single-channel framing FSM with beat counter; flags done/err and reports packet length.
// Latency: state, done and length reflect a beat one cycle after it; err pulse likewise.
// Backpressure: none, every beat is consumed in the cycle it is presented.
module pkt_chan_fsm
    import pkt_frame_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = len_w(MAX_LEN)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_valid,
    input  logic                 i_head,
    input  logic                 i_tail,
    output logic [STATE_W-1:0]   o_state,
    output logic                 o_done,
    output logic                 o_err,
    output logic [LEN_W-1:0]     o_len
);

    // A body beat in DATA is accepted only while the count stays below this,
    // leaving room for the tail so a finished packet never exceeds MAX_LEN.
    localparam logic [LEN_W-1:0] BODY_CAP = LEN_W'(MAX_LEN - 1);
    localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

    chan_state_e        r_state;
    chan_state_e        w_state_nxt;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   w_cnt_nxt;
    logic               r_err_pulse;
    beat_e              w_beat;

    assign w_beat = classify(i_valid, i_head, i_tail);

    // Next-state and beat-count decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                case (w_beat)
                    BEAT_H:    begin w_state_nxt = ST_HEAD; w_cnt_nxt = ONE; end
                    BEAT_NONE: w_state_nxt = ST_IDLE;
                    default:   w_state_nxt = ST_ERR;
                endcase
            end
            ST_HEAD: begin
                case (w_beat)
                    BEAT_BODY: begin w_state_nxt = ST_DATA; w_cnt_nxt = r_cnt + ONE; end
                    BEAT_T:    begin w_state_nxt = ST_TAIL; w_cnt_nxt = r_cnt + ONE; end
                    BEAT_NONE: w_state_nxt = ST_HEAD;
                    default:   w_state_nxt = ST_ERR;
                endcase
            end
            ST_DATA: begin
                case (w_beat)
                    BEAT_BODY: begin
                        if (r_cnt < BODY_CAP) begin
                            w_state_nxt = ST_DATA;
                            w_cnt_nxt   = r_cnt + ONE;
                        end else begin
                            w_state_nxt = ST_ERR;
                        end
                    end
                    BEAT_T:    begin w_state_nxt = ST_TAIL; w_cnt_nxt = r_cnt + ONE; end
                    BEAT_NONE: w_state_nxt = ST_DATA;
                    default:   w_state_nxt = ST_ERR;
                endcase
            end
            ST_TAIL: begin
                case (w_beat)
                    BEAT_H:    begin w_state_nxt = ST_HEAD; w_cnt_nxt = ONE; end
                    BEAT_NONE: w_state_nxt = ST_IDLE;
                    default:   w_state_nxt = ST_ERR;
                endcase
            end
            ST_ERR: begin
                if (w_beat == BEAT_H) begin
                    w_state_nxt = ST_HEAD;
                    w_cnt_nxt   = ONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, count and error-entry pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_err_pulse <= (w_state_nxt == ST_ERR) && (r_state != ST_ERR);
        end
    end

    assign o_state = r_state;
    assign o_done  = (r_state == ST_TAIL);
    assign o_err   = r_err_pulse;
    assign o_len   = o_done ? r_cnt : '0;

endmodule

// File: rtl/pkt_frame_mon.sv
// Multi-channel packet framing monitor with saturating aggregate done/error counters.
// Latency: per-channel outputs one cycle after the beat; counters one cycle after the pulses.
// Backpressure: none, inputs are observed every cycle and never stalled.
module pkt_frame_mon
    import pkt_frame_pkg::*;
#(
    parameter int   NCH     = 4,
    parameter int   MAX_LEN = 16,
    parameter int   CNT_W   = 8,
    localparam int  LEN_W   = len_w(MAX_LEN)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NCH-1:0]         valid,
    input  logic [NCH-1:0]         head,
    input  logic [NCH-1:0]         tail,
    input  logic                   clr,
    output logic [3*NCH-1:0]       state,
    output logic [NCH-1:0]         pkt_done,
    output logic [NCH-1:0]         pkt_err,
    output logic [LEN_W*NCH-1:0]   pkt_len,
    output logic [CNT_W-1:0]       done_cnt,
    output logic [CNT_W-1:0]       err_cnt
);

    localparam int SUM_W = $clog2(NCH + 1);
    localparam int ACC_W = CNT_W + SUM_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [STATE_W-1:0] w_state [NCH];
    logic [LEN_W-1:0]   w_len   [NCH];
    logic               w_done  [NCH];
    logic               w_err   [NCH];

    logic [SUM_W-1:0]   w_done_sum;
    logic [SUM_W-1:0]   w_err_sum;
    logic [ACC_W-1:0]   w_done_acc;
    logic [ACC_W-1:0]   w_err_acc;
    logic [CNT_W-1:0]   w_done_nxt;
    logic [CNT_W-1:0]   w_err_nxt;
    logic [CNT_W-1:0]   r_done_cnt;
    logic [CNT_W-1:0]   r_err_cnt;

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_chan
            pkt_chan_fsm #(
                .MAX_LEN (MAX_LEN),
                .LEN_W   (LEN_W)
            ) u_chan (
                .clk     (clk),
                .reset_n (reset_n),
                .i_valid (valid[g]),
                .i_head  (head[g]),
                .i_tail  (tail[g]),
                .o_state (w_state[g]),
                .o_done  (w_done[g]),
                .o_err   (w_err[g]),
                .o_len   (w_len[g])
            );
        end
    endgenerate

    // Pack channel outputs onto the flat buses and count this cycle's pulses.
    always_comb begin
        state      = '0;
        pkt_len    = '0;
        pkt_done   = '0;
        pkt_err    = '0;
        w_done_sum = '0;
        w_err_sum  = '0;
        for (int i = 0; i < NCH; i++) begin
            state[3*i +: 3]         = w_state[i];
            pkt_len[LEN_W*i +: LEN_W] = w_len[i];
            pkt_done[i]             = w_done[i];
            pkt_err[i]              = w_err[i];
            w_done_sum              = w_done_sum + SUM_W'(w_done[i]);
            w_err_sum               = w_err_sum + SUM_W'(w_err[i]);
        end
    end

    // Saturating add done in a wider accumulator so several simultaneous pulses cannot wrap.
    always_comb begin
        w_done_acc = ACC_W'(r_done_cnt) + ACC_W'(w_done_sum);
        w_err_acc  = ACC_W'(r_err_cnt) + ACC_W'(w_err_sum);
        w_done_nxt = (w_done_acc > ACC_W'(CNT_MAX)) ? CNT_MAX : w_done_acc[CNT_W-1:0];
        w_err_nxt  = (w_err_acc > ACC_W'(CNT_MAX)) ? CNT_MAX : w_err_acc[CNT_W-1:0];
    end

    // Aggregate counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done_cnt <= '0;
            r_err_cnt  <= '0;
        end else if (clr) begin
            r_done_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_done_cnt <= w_done_nxt;
            r_err_cnt  <= w_err_nxt;
        end
    end

    assign done_cnt = r_done_cnt;
    assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_pkt_frame_mon.sv
// Scoreboard bench for pkt_frame_mon: directed framing scenarios then randomized beats.
// Latency: expectations tagged with the clock edge at which they must appear.
// Backpressure: n/a.
module tb_pkt_frame_mon;

    localparam int NCH     = 4;
    localparam int MAX_LEN = 4;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b1;
    logic [NCH-1:0]        valid = '0;
    logic [NCH-1:0]        head = '0;
    logic [NCH-1:0]        tail = '0;
    logic                  clr = 1'b0;
    logic [3*NCH-1:0]      state;
    logic [NCH-1:0]        pkt_done;
    logic [NCH-1:0]        pkt_err;
    logic [LEN_W*NCH-1:0]  pkt_len;
    logic [CNT_W-1:0]      done_cnt;
    logic [CNT_W-1:0]      err_cnt;

    pkt_frame_mon #(
        .NCH     (NCH),
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .valid    (valid),
        .head     (head),
        .tail     (tail),
        .clr      (clr),
        .state    (state),
        .pkt_done (pkt_done),
        .pkt_err  (pkt_err),
        .pkt_len  (pkt_len),
        .done_cnt (done_cnt),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Per-edge expectation and per-pulse expectation.
    typedef struct {
        int                    tag;
        logic [3*NCH-1:0]      st;
        logic [LEN_W*NCH-1:0]  lens;
        int                    dcnt;
        int                    ecnt;
    } cyc_rec_t;

    typedef struct {
        int tag;
        int ch;
        bit is_err;
    } evt_t;

    cyc_rec_t rec_q[$];
    evt_t     evt_q[$];

    // Reference model: a channel is either idle, inside a packet of m_len beats,
    // just finished a packet, or in error; beats are judged by framing rules.
    int m_len    [NCH];
    bit m_in_pkt [NCH];
    bit m_done   [NCH];
    bit m_err    [NCH];
    int m_dcnt = 0, m_ecnt = 0, pend_d = 0, pend_e = 0;

    task automatic model_clear();
        for (int i = 0; i < NCH; i++) begin
            m_len[i] = 0; m_in_pkt[i] = 0; m_done[i] = 0; m_err[i] = 0;
        end
        m_dcnt = 0; m_ecnt = 0; pend_d = 0; pend_e = 0;
    endtask

    // Drive one cycle of beats (consumed at the next edge) and record what must follow.
    task automatic step(input logic [NCH-1:0] v, input logic [NCH-1:0] h,
                        input logic [NCH-1:0] t, input bit c);
        cyc_rec_t r;
        evt_t     e;
        int       nd;
        int       ne;
        @(posedge clk);
        #1;
        valid = v; head = h; tail = t; clr = c;
        r.tag = cyc + 1;
        r.st = '0;
        r.lens = '0;
        m_dcnt = c ? 0 : ((m_dcnt + pend_d > CMAX) ? CMAX : m_dcnt + pend_d);
        m_ecnt = c ? 0 : ((m_ecnt + pend_e > CMAX) ? CMAX : m_ecnt + pend_e);
        nd = 0;
        ne = 0;
        for (int i = 0; i < NCH; i++) begin
            bit was_err, to_err, fin, is_h, is_t, is_b;
            int sv;
            was_err = m_err[i];
            to_err  = 0;
            fin     = 0;
            is_h = v[i] && h[i] && !t[i];
            is_t = v[i] && t[i] && !h[i];
            is_b = v[i] && !h[i] && !t[i];
            if (m_in_pkt[i]) begin
                if (is_b) begin
                    if (m_len[i] < MAX_LEN - 1) m_len[i]++;
                    else to_err = 1;
                end else if (is_t) begin
                    m_len[i]++;
                    fin = 1;
                end else if (v[i]) begin
                    to_err = 1;
                end
            end else if (is_h) begin
                m_len[i] = 1; m_in_pkt[i] = 1; m_err[i] = 0;
            end else if (v[i]) begin
                to_err = 1;
            end
            m_done[i] = fin;
            if (fin) m_in_pkt[i] = 0;
            if (to_err) begin m_in_pkt[i] = 0; m_err[i] = 1; end
            if (to_err && !was_err) begin
                e.tag = r.tag; e.ch = i; e.is_err = 1; evt_q.push_back(e); ne++;
            end
            if (fin) begin
                e.tag = r.tag; e.ch = i; e.is_err = 0; evt_q.push_back(e); nd++;
            end
            sv = m_err[i] ? 4 : m_done[i] ? 3 : m_in_pkt[i] ? ((m_len[i] == 1) ? 1 : 2) : 0;
            r.st[3*i +: 3] = 3'(sv);
            if (m_done[i]) r.lens[LEN_W*i +: LEN_W] = LEN_W'(m_len[i]);
        end
        pend_d = nd;
        pend_e = ne;
        r.dcnt = m_dcnt;
        r.ecnt = m_ecnt;
        rec_q.push_back(r);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        valid = '0; head = '0; tail = '0; clr = 1'b0;
        rec_q.delete();
        evt_q.delete();
        model_clear();
        #1;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_done", 64'(pkt_done), 64'd0);
        chk("rst_err", 64'(pkt_err), 64'd0);
        chk("rst_len", 64'(pkt_len), 64'd0);
        chk("rst_done_cnt", 64'(done_cnt), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Monitor: pops a pulse expectation for every pulse the DUT shows and a
    // per-edge expectation for state, lengths and counters.
    cyc_rec_t mr;
    evt_t     me;
    always @(negedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (pkt_done[i] || pkt_err[i]) begin
                if (evt_q.size() == 0) begin
                    chk("unexpected_pulse_ch", 64'(i), 64'hFFFF);
                end else begin
                    me = evt_q.pop_front();
                    chk("pulse_tag", 64'(cyc), 64'(me.tag));
                    chk("pulse_ch", 64'(i), 64'(me.ch));
                    chk("pulse_is_err", 64'(pkt_err[i]), 64'(me.is_err));
                end
            end
        end
        while (evt_q.size() > 0 && evt_q[0].tag <= cyc) begin
            me = evt_q.pop_front();
            chk("missed_pulse_ch", 64'hFFFF, 64'(me.ch));
        end
        if (rec_q.size() > 0 && rec_q[0].tag <= cyc) begin
            mr = rec_q.pop_front();
            chk("rec_tag", 64'(cyc), 64'(mr.tag));
            chk("state", 64'(state), 64'(mr.st));
            chk("pkt_len", 64'(pkt_len), 64'(mr.lens));
            chk("done_cnt", 64'(done_cnt), 64'(mr.dcnt));
            chk("err_cnt", 64'(err_cnt), 64'(mr.ecnt));
        end
    end

    task automatic rand_beat(output logic v, output logic h, output logic t);
        int r;
        r = $urandom_range(0, 99);
        if (r < 30)      begin v = 0; h = 1'($urandom); t = 1'($urandom); end
        else if (r < 65) begin v = 1; h = 0; t = 0; end
        else if (r < 80) begin v = 1; h = 1; t = 0; end
        else if (r < 95) begin v = 1; h = 0; t = 1; end
        else             begin v = 1; h = 1; t = 1; end
    endtask

    initial begin
        logic [NCH-1:0] rv, rh, rt;
        model_clear();
        do_reset();

        // Ch0: H, body, body, T -> length 4.
        step(4'b0001, 4'b0001, 4'b0000, 0);
        step(4'b0001, 4'b0000, 4'b0000, 0);
        step(4'b0001, 4'b0000, 4'b0000, 0);
        step(4'b0001, 4'b0000, 4'b0001, 0);
        idle(2);

        // Ch1: H, two idle cycles, T -> length 2.
        step(4'b0010, 4'b0010, 4'b0000, 0);
        idle(2);
        step(4'b0010, 4'b0000, 4'b0010, 0);
        idle(2);

        // Ch2: overlength on the third body beat, then resync with H.
        step(4'b0100, 4'b0100, 4'b0000, 0);
        step(4'b0100, 4'b0000, 4'b0000, 0);
        step(4'b0100, 4'b0000, 4'b0000, 0);
        step(4'b0100, 4'b0000, 4'b0000, 0);
        idle(2);
        step(4'b0100, 4'b0100, 4'b0000, 0);
        step(4'b0100, 4'b0000, 4'b0100, 0);
        idle(2);

        // Ch0 and ch3 finish together, first counted, then cleared in the pulse cycle.
        step(4'b1001, 4'b1001, 4'b0000, 1);
        step(4'b1001, 4'b0000, 4'b1001, 0);
        step('0, '0, '0, 0);
        chk("dual_done", 64'(pkt_done), 64'b1001);
        step('0, '0, '0, 0);
        chk("dual_done_cnt", 64'(done_cnt), 64'd2);
        step(4'b1001, 4'b1001, 4'b0000, 0);
        step(4'b1001, 4'b0000, 4'b1001, 0);
        step('0, '0, '0, 1);
        step('0, '0, '0, 0);
        chk("clr_over_inc", 64'(done_cnt), 64'd0);
        idle(1);

        // Ch0 reset mid-packet.
        step(4'b0001, 4'b0001, 4'b0000, 0);
        step(4'b0001, 4'b0000, 4'b0000, 0);
        do_reset();
        idle(2);

        // Five error entries on ch0 saturate the error counter.
        for (int k = 0; k < 5; k++) begin
            step(4'b0001, 4'b0001, 4'b0000, 0);
            step(4'b0001, 4'b0001, 4'b0001, 0);
        end
        idle(3);
        chk("err_sat", 64'(err_cnt), 64'(CMAX));

        // Randomized beats on all channels with occasional clear and one reset.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NCH; i++) begin
                logic bv, bh, bt;
                rand_beat(bv, bh, bt);
                rv[i] = bv; rh[i] = bh; rt[i] = bt;
            end
            step(rv, rh, rt, ($urandom_range(0, 5) == 0));
            if (n == 700) do_reset();
        end
        idle(3);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pkt_frame_mon.md
PKT_FRAME_MON -- requirements
Module: pkt_frame_mon

Interface
REQ-001 Parameter NCH, default 4, number of independent packet channels (1..16).
REQ-002 Parameter MAX_LEN, default 16, maximum legal beats per packet including head and tail (3..255).
REQ-003 Parameter CNT_W, default 8, width of the aggregate done/error counters.
REQ-004 Derived constant LEN_W = clog2(MAX_LEN+1).
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 valid  input  NCH  per-channel beat qualifier.
REQ-008 head  input  NCH  per-channel first-beat marker; meaningful only with valid.
REQ-009 tail  input  NCH  per-channel last-beat marker; meaningful only with valid.
REQ-010 clr  input  1  synchronous clear of both aggregate counters.
REQ-011 state  output  3*NCH  registered per-channel FSM state; channel i occupies bits [3i+2:3i].
REQ-012 pkt_done  output  NCH  one-cycle pulse when a channel's state is TAIL.
REQ-013 pkt_err  output  NCH  one-cycle pulse on the first cycle a channel is in ERR.
REQ-014 pkt_len  output  LEN_W*NCH  beat count of the packet just completed; valid while pkt_done is high.
REQ-015 done_cnt  output  CNT_W  saturating total of pkt_done pulses across all channels.
REQ-016 err_cnt  output  CNT_W  saturating total of pkt_err pulses across all channels.

Function
REQ-017 Each channel SHALL run an independent FSM with states IDLE=0, HEAD=1, DATA=2, TAIL=3, ERR=4.
REQ-018 Beat = valid&!head&!tail (body), valid&head&!tail (H), valid&tail&!head (T), valid&head&tail (HT, always illegal).
REQ-019 IDLE: H->HEAD; body, T or HT->ERR; no valid->IDLE.
REQ-020 HEAD: body->DATA; T->TAIL; H or HT->ERR; no valid->HEAD (stall holds state).
REQ-021 DATA: body->DATA if beat count < MAX_LEN-1, else ->ERR (overlength); T->TAIL; H or HT->ERR; no valid->DATA.
REQ-022 TAIL: H->HEAD (back-to-back packet); no valid->IDLE; body, T or HT->ERR.
REQ-023 ERR: H->HEAD (resync); otherwise stay in ERR.
REQ-024 Beat counter per channel: loads 1 on any transition into HEAD; +1 on each body or T beat accepted in HEAD/DATA; never exceeds MAX_LEN.
REQ-025 pkt_len[i] SHALL equal the channel's beat count (head through tail inclusive) whenever state is TAIL; 0 otherwise.
REQ-026 pkt_done[i] SHALL be high exactly when state[i]==TAIL, i.e. one cycle after the tail beat.
REQ-027 pkt_err[i] SHALL be high for one cycle on each entry into ERR; remaining in ERR produces no further pulses.
REQ-028 Each cycle done_cnt SHALL add popcount(pkt_done) and err_cnt SHALL add popcount(pkt_err), saturating at 2^CNT_W-1.
REQ-029 clr SHALL zero both counters and take priority over same-cycle increments.
REQ-030 Channels SHALL not interact except through the aggregate counters.

Reset
REQ-031 reset_n low SHALL immediately force all states to IDLE and all beat counters, pkt_done, pkt_err, pkt_len, done_cnt and err_cnt to 0.
REQ-032 Reset asserted mid-packet SHALL discard the packet with no pkt_done or pkt_err pulse.
REQ-033 After reset_n rises, the first clock edge SHALL evaluate transitions normally.

Structure
REQ-034 State encoding, LEN_W function and beat-class constants SHALL reside in shared package pkt_frame_pkg.
REQ-035 Per-channel FSM plus beat counter SHALL be sub-module pkt_chan_fsm, instantiated NCH times by generate; aggregation lives in the top level.

Verification
REQ-036 Ch0 H, body, body, T on consecutive cycles -> state 1,2,2,3,0; pkt_done[0] one cycle with pkt_len=4; done_cnt=1.
REQ-037 Ch1 H, 2-cycle valid gap, T -> state holds HEAD through gap, then TAIL; pkt_len=2, no error.
REQ-038 MAX_LEN=4, ch2 H then 3 body beats -> ERR on 3rd body beat, pkt_err[2] single pulse, err_cnt=1; later H -> HEAD.
REQ-039 Ch0 and ch3 tail on the same cycle -> pkt_done=4'b1001, done_cnt increments by 2; with clr same cycle -> done_cnt=0.
REQ-040 Ch0 H, body, then reset_n low for 1 cycle -> state 0 immediately, no pkt_done/pkt_err, counters 0.
REQ-041 CNT_W=2, five error events on ch0 -> err_cnt saturates at 3.
